mux_arb_reg: RTL

- Parametrised N-input, WIDTH-bit registered multiplexer with a valid/ready handshake on every input and on the output.
- Two selection modes:
  - explicit select, like the existing combinational muxes but with flow control;
  - round-robin arbitration.
- Sits between multiple datapath producers (register file read ports, ALU/shifter results, memory return) and a single consumer stage.
- Replaces ad-hoc width/size-specific muxes where back-pressure is needed.

---
 rtl/mux_arb_pkg.sv | 17 +
 rtl/mux_arb_reg_rr_arbiter.sv | 31 +++
 rtl/mux_arb_reg.sv | 83 ++++++++
 3 files changed

// File: rtl/mux_arb_pkg.sv
// Shared definitions for the registered N-input mux/arbiter: selection modes
// and a constant clog2 for tools without $clog2.
package mux_arb_pkg;

  typedef enum logic {
    MODE_SEL = 1'b0,
    MODE_RR  = 1'b1
  } mode_e;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int unsigned v = 1; v < 32'(value); v = v << 1) r++;
    return r;
  endfunction

endpackage

// File: rtl/mux_arb_reg_rr_arbiter.sv
// Combinational round-robin arbiter: first requester after 'last', wrapping
// modulo N (N need not be a power of two).
module rr_arbiter
  import mux_arb_pkg::*;
#(
  parameter int N    = 4,
  parameter int SELW = clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [SELW-1:0] last,
  output logic            gnt_valid,
  output logic [SELW-1:0] gnt_idx
);

  always_comb begin
    int unsigned idx;
    gnt_valid = 1'b0;
    gnt_idx   = '0;
    idx       = 0;
    // Scan last+1 .. last+N; the sum stays below 2N so one subtraction wraps it.
    for (int unsigned k = 1; k <= N; k++) begin
      idx = 32'(last) + k;
      if (idx >= N) idx = idx - N;
      if (!gnt_valid && req[idx]) begin
        gnt_valid = 1'b1;
        gnt_idx   = SELW'(idx);
      end
    end
  end

endmodule

// File: rtl/mux_arb_reg.sv
// N-input registered multiplexer with valid/ready on every channel; selects
// either an explicit channel or round-robin among valid channels.
module mux_arb_reg
  import mux_arb_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int N     = 4,
  parameter int SELW  = clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  input  logic [N-1:0]         in_valid,
  input  logic [N*WIDTH-1:0]   in_data,
  output logic [N-1:0]         in_ready,
  output logic                 out_valid,
  output logic [WIDTH-1:0]     out_data,
  output logic [SELW-1:0]      out_src,
  input  logic                 out_ready
);

  logic             ld;
  logic             accept;
  logic             sel_valid;
  logic             rr_valid;
  logic [SELW-1:0]  rr_idx;
  logic             gnt_valid;
  logic [SELW-1:0]  gnt_idx;
  logic [SELW-1:0]  last;
  logic [WIDTH-1:0] gnt_data;

  rr_arbiter #(
    .N    (N),
    .SELW (SELW)
  ) u_rr (
    .req       (in_valid),
    .last      (last),
    .gnt_valid (rr_valid),
    .gnt_idx   (rr_idx)
  );

  // Explicit select looks only at in_valid[sel]; out-of-range sel matches no channel.
  always_comb begin
    sel_valid = 1'b0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(sel) == i && in_valid[i]) sel_valid = 1'b1;
    end
  end

  assign gnt_valid = (mode == MODE_RR) ? rr_valid : sel_valid;
  assign gnt_idx   = (mode == MODE_RR) ? rr_idx   : sel;
  assign ld        = ~out_valid | out_ready;
  assign accept    = ld & gnt_valid;

  always_comb begin
    in_ready = '0;
    gnt_data = '0;
    for (int unsigned i = 0; i < N; i++) begin
      if (32'(gnt_idx) == i) begin
        gnt_data    = in_data[i*WIDTH +: WIDTH];
        in_ready[i] = accept & rst_n;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_src   <= '0;
      last      <= SELW'(N - 1);
    end else if (ld) begin
      out_valid <= gnt_valid;
      if (gnt_valid) begin
        out_data <= gnt_data;
        out_src  <= gnt_idx;
        if (mode == MODE_RR) last <= gnt_idx;
      end
    end
  end

endmodule
